// File: rtl/xc_malu_seq_if.sv
// Request/response bundle between the execute stage and the multi-precision ALU sequencer.
// master = pipeline side, slave = sequencer side.
interface xc_malu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic              flush;
  logic              valid;
  logic              op_madd;
  logic              op_msub;
  logic              op_mmul;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   rs3;
  logic              ready;
  logic              busy;
  logic [2*XLEN-1:0] result;

  modport master (
    output flush, valid, op_madd, op_msub, op_mmul, rs1, rs2, rs3,
    input  ready, busy, result
  );

  modport slave (
    input  flush, valid, op_madd, op_msub, op_mmul, rs1, rs2, rs3,
    output ready, busy, result
  );
endinterface

// File: rtl/xc_malu_seq.sv
// Multi-cycle sequencer for xc.madd.3 / xc.msub.3 / xc.mmul.3 built around one 33-bit adder.
// madd/msub resolve at accept; mmul runs 32 shift-add iterations.
module xc_malu_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic           g_clk,
  input logic           g_rst,
  xc_malu_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {OpNone, OpMadd, OpMsub, OpMmul} op_e;

  state_e            state_q;
  op_e               op_q;
  logic [XLEN-1:0]   rs2_q;
  logic [2*XLEN:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*XLEN-1:0] result_q;
  logic              ready_q;
  logic              busy_q;

  logic            in_mmul;
  logic            in_msub;
  logic            any_op;
  logic            accept;
  logic            last_iter;
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_cin;
  logic [XLEN:0]   sum;
  logic [2*XLEN:0] mul_step;
  logic [2*XLEN:0] mul_next;

  assign in_mmul   = bus.op_mmul;
  assign in_msub   = bus.op_msub & ~bus.op_mmul;
  assign any_op    = bus.op_madd | bus.op_msub | bus.op_mmul;
  assign accept    = (state_q == StIdle) & bus.valid & any_op & ~bus.flush;
  assign last_iter = (cnt_q == CntW'(XLEN - 1));

  // The single adder: incoming operands while idle, accumulator + rs2 while iterating.
  always_comb begin
    add_a   = bus.rs1;
    add_b   = in_msub ? ~bus.rs2 : bus.rs2;
    add_cin = in_msub ? ~bus.rs3[0] : bus.rs3[0];
    if (state_q == StRun) begin
      add_a   = acc_q[2*XLEN-1:XLEN];
      add_b   = rs2_q;
      add_cin = 1'b0;
    end
  end

  assign sum      = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};
  assign mul_step = acc_q[0] ? {sum, acc_q[XLEN-1:0]} : acc_q;
  assign mul_next = mul_step >> 1;

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= StIdle;
      op_q     <= OpNone;
      rs2_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              rs2_q   <= bus.rs2;
              if (in_mmul) begin
                op_q  <= OpMmul;
                acc_q <= {1'b0, bus.rs3, bus.rs1};
              end else begin
                op_q  <= in_msub ? OpMsub : OpMadd;
                // Bit XLEN holds carry for madd, borrow for msub.
                acc_q <= {{XLEN{1'b0}}, in_msub ? ~sum[XLEN] : sum[XLEN], sum[XLEN-1:0]};
              end
            end
          end
          StRun: begin
            if (op_q == OpMmul) begin
              acc_q <= mul_next;
              cnt_q <= cnt_q + CntW'(1);
              if (last_iter) begin
                state_q  <= StDone;
                ready_q  <= 1'b1;
                result_q <= mul_next[2*XLEN-1:0];
              end
            end else begin
              state_q  <= StDone;
              ready_q  <= 1'b1;
              result_q <= {{(XLEN-1){1'b0}}, acc_q[XLEN:0]};
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A flush landing in the DONE cycle must hide that cycle's ready pulse.
  assign bus.ready  = ready_q & ~bus.flush;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule

// File: doc/xc_malu_seq.md
Name: xc_malu_seq

Overview:
- Multi-cycle sequencer for the XCrypto multi-precision ALU.
- Executes xc.madd.3, xc.msub.3 and xc.mmul.3 on a single shared 33-bit adder.
- madd.3 and msub.3 take one adder pass; mmul.3 takes 32 shift-add passes.
- Sits beside the execute stage. The pipeline stalls on a valid/ready handshake until the 64-bit result is returned.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; the iteration counter is sized $clog2(XLEN).

Ports:
- g_clk  input  1  clock; all state updates on rising edge
- g_rst  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; abandons any in-flight operation
- valid  input  1  request; sampled only in IDLE
- op_madd  input  1  select xc.madd.3
- op_msub  input  1  select xc.msub.3
- op_mmul  input  1  select xc.mmul.3
- rs1  input  XLEN  operand 1
- rs2  input  XLEN  operand 2
- rs3  input  XLEN  operand 3; only bit 0 is used for madd/msub
- ready  output  1  one-cycle pulse; result is valid in this cycle
- busy  output  1  high whenever state != IDLE
- result  output  2*XLEN  {hi,lo} result; registered

Behaviour:
- States: IDLE, RUN, DONE. Registers: acc[64:0], op latch, cnt[4:0].
- Reset (g_rst=1 at any edge, including mid-operation):
  - state=IDLE, acc=0, cnt=0, op latch=0.
  - result=0, ready=0, busy=0.
  - Reset dominates flush and valid.
- Accept (IDLE & valid & any op bit & !flush):
  - Latch the operation, using priority mmul > msub > madd when more than one op bit is set.
  - Go to RUN.
  - Operands are latched at accept, so the caller need not hold them afterwards.
- valid with no op bit set: ignored, stay in IDLE, no ready.
- madd:
  - Accept loads acc = {rs1+rs2+rs3[0]} as a 33-bit sum.
  - RUN lasts 1 cycle.
  - result = {31'b0, carry, sum[31:0]}.
- msub:
  - Accept computes rs1 + ~rs2 + !rs3[0] through the same adder.
  - borrow = !carry.
  - result = {31'b0, borrow, diff[31:0]}.
- mmul:
  - Accept loads acc = {1'b0, rs3, rs1} and cnt=0. rs2 is held in the op latch.
  - Each RUN cycle:
    - if acc[0]: acc[64:32] = acc[63:32] + rs2 (33-bit);
    - then acc = acc >> 1 (logical);
    - cnt++.
  - Leave RUN when cnt==31 completes (32 iterations).
  - Final acc[63:0] = rs1*rs2 + rs3. The result never exceeds 2^64-1, so there is no overflow.
- Transitions:
  - RUN → DONE when finished.
  - DONE → IDLE unconditionally after 1 cycle.
  - ready=1 only in DONE.
  - result updates on entry to DONE and holds until the next DONE or reset.
- Latency, request accepted in cycle T:
  - madd/msub: ready in T+2.
  - mmul: ready in T+33.
  - Next request accepted no earlier than T+3 (madd/msub) or T+34 (mmul).
- valid held high during RUN/DONE is ignored. Only IDLE samples it.
- flush:
  - In any state, next state = IDLE and cnt=0.
  - ready is suppressed in that cycle even if state is DONE.
  - result is not updated.
  - flush with valid in IDLE: flush wins and there is no accept.
- Only one adder instance exists. All three ops share it, muxed by the op latch.

Test Plan:
- madd: rs1=0xFFFFFFFF, rs2=0x1, rs3=0x3 → ready at T+2, result=0x00000001_00000001; busy high T+1..T+2.
- msub: rs1=0x0, rs2=0x1, rs3=0x0 → result=0x00000001_FFFFFFFF. Repeat with rs1=5, rs2=2, rs3=1 → result=0x00000000_00000002.
- mmul: rs1=rs2=rs3=0xFFFFFFFF → ready exactly at T+33, result=0xFFFFFFFF_00000000. Also rs1=3, rs2=5, rs3=7 → result=0x16.
- flush at T+10 of an mmul:
  - state is IDLE at T+11; ready never pulses; result keeps its previous value.
  - A madd accepted at T+11 returns its correct result at T+13.
- g_rst asserted mid-mmul (T+5, one cycle):
  - all outputs are 0 the next cycle.
  - valid with op_madd|op_mmul both set executes mmul (priority check).
  - valid with no op bits set produces no ready for 40 cycles.
- Back-to-back requests with valid held high: a madd then an mmul accept at T and T+3, with ready at T+2 and T+36 and no spurious ready pulses.
